regfile_ir_limiter: RTL and testbench
=====================================

REGFILE_IR_LIMITER -- requirements
Module: regfile_ir_limiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: Clk and Reset.
REQ-002 The port list SHALL be exactly as follows:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high clear.
- Load_ir  in  1  instruction-register load enable.
- Entrada  in  32  instruction word from instruction memory.
- RegWrite  in  1  register-file write enable.
- WriteData  in  64  register-file write data.
- lim  in  2  limiter mode select.
- LimIn  in  64  raw memory data (MDR) to limit.
- Instr31_0  out  32  full IR contents.
- Instr19_15  out  5  IR[19:15] (rs1).
- Instr24_20  out  5  IR[24:20] (rs2).
- Instr11_7  out  5  IR[11:7] (rd).
- Instr6_0  out  7  IR[6:0] (opcode).
- ReadData1  out  64  register x[IR[19:15]].
- ReadData2  out  64  register x[IR[24:20]].
- LimOut  out  64  limited and extended data.

Function
REQ-003 The IR SHALL be a 32-bit register that captures Entrada on a rising Clk edge when Load_ir=1, and SHALL hold its value otherwise.
REQ-004 Instr31_0, Instr19_15, Instr24_20, Instr11_7 and Instr6_0 SHALL be combinational slices of the IR register, not of Entrada, so a new instruction appears one cycle after the load.
REQ-005 The register file SHALL hold 32 registers of 64 bits each, indexed 0-31.
REQ-006 The read address of port 1 SHALL be IR[19:15] and the read address of port 2 SHALL be IR[24:20].
REQ-007 Register-file reads SHALL be combinational from the current register contents.
REQ-008 A register-file write SHALL occur on a rising Clk edge when RegWrite=1, storing WriteData into x[IR[11:7]].
REQ-009 Register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-010 Read during write to the same register SHALL return the old value in that cycle and the new value after the edge; there is no bypass.
REQ-011 When Load_ir and RegWrite are asserted on the same edge, the write SHALL use the rd field of the IR value held before that edge.
REQ-012 The limiter SHALL be purely combinational and SHALL select by lim as follows:
- 00: LimOut = LimIn (doubleword).
- 01: LimOut = LimIn[31:0] sign-extended to 64 bits (word).
- 10: LimOut = LimIn[15:0] sign-extended to 64 bits (halfword).
- 11: LimOut = LimIn[7:0] zero-extended to 64 bits (unsigned byte).
REQ-013 Any X or Z value on lim SHALL produce LimOut = 0.

Reset
REQ-014 Reset=1 SHALL, immediately and without waiting for a clock edge, clear the IR to 0 and clear all 32 registers to 0.
REQ-015 While Reset=1, all writes and IR loads SHALL be blocked.
REQ-016 During reset, Instr* outputs, ReadData1 and ReadData2 SHALL read 0; LimOut is not reset and SHALL always follow lim and LimIn.
REQ-017 Asserting Reset in the middle of an operation SHALL discard any pending write on that edge.
REQ-018 After Reset is released, the first rising edge SHALL behave normally.

Verification
REQ-019 IR load: Entrada=0x00B50533, Load_ir=1, one edge -> Instr6_0=0x33, Instr11_7=10, Instr19_15=10, Instr24_20=11; with Load_ir=0 and a new Entrada, the IR value is held.
REQ-020 Write/read: IR rd=5, WriteData=0x1122334455667788, RegWrite=1, one edge; then rs1=5 -> ReadData1=0x1122334455667788 on the next cycle, and 0 during the write cycle.
REQ-021 x0: write 0xFFFF_FFFF_FFFF_FFFF to rd=0 -> ReadData1 and ReadData2 with rs=0 read 0.
REQ-022 Limiter with LimIn=0x0123_4567_89AB_CDEF:
- lim=00 -> 0x0123456789ABCDEF.
- lim=01 -> 0xFFFFFFFF89ABCDEF.
- lim=10 -> 0xFFFFFFFFFFFFCDEF.
- lim=11 -> 0x00000000000000EF.
REQ-023 Limiter positive sign: LimIn=0x7FFF_7FFF with lim=10 -> 0x0000000000007FFF.
REQ-024 Asynchronous reset: after writing x3=0xAA, pulse Reset between clock edges -> x3 reads 0 and Instr31_0=0 before the next edge.

Source files
------------

// File: rtl/regfile_ir_limiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ir_limiter
// Brief    : Instruction register, 32x64 register file and load-data limiter.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_ir_limiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load_ir,
    input  logic [31:0] Entrada,
    input  logic        RegWrite,
    input  logic [63:0] WriteData,
    input  logic [1:0]  lim,
    input  logic [63:0] LimIn,
    output logic [31:0] Instr31_0,
    output logic [4:0]  Instr19_15,
    output logic [4:0]  Instr24_20,
    output logic [4:0]  Instr11_7,
    output logic [6:0]  Instr6_0,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2,
    output logic [63:0] LimOut
);

    localparam int c_NUM_REGS = 32;

    logic [31:0] r_ir;
    logic [63:0] r_regs [c_NUM_REGS];
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [63:0] w_limOut;

    // Instruction register; fields are decoded from the stored word only.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ir <= '0;
        end else if (Load_ir) begin
            r_ir <= Entrada;
        end
    end

    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];
    assign w_rd  = r_ir[11:7];

    assign Instr31_0  = r_ir;
    assign Instr19_15 = w_rs1;
    assign Instr24_20 = w_rs2;
    assign Instr11_7  = w_rd;
    assign Instr6_0   = r_ir[6:0];

    // rd comes from the IR before the edge, so a simultaneous IR load does
    // not redirect the write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (RegWrite && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= WriteData;
        end
    end

    assign ReadData1 = (w_rs1 == 5'd0) ? 64'd0 : r_regs[w_rs1];
    assign ReadData2 = (w_rs2 == 5'd0) ? 64'd0 : r_regs[w_rs2];

    // An unknown mode select falls through to the zero default.
    always_comb begin
        w_limOut = '0;
        case (lim)
            2'b00:   w_limOut = LimIn;
            2'b01:   w_limOut = {{32{LimIn[31]}}, LimIn[31:0]};
            2'b10:   w_limOut = {{48{LimIn[15]}}, LimIn[15:0]};
            2'b11:   w_limOut = {56'd0, LimIn[7:0]};
            default: w_limOut = '0;
        endcase
    end

    assign LimOut = w_limOut;

endmodule
`default_nettype wire

// File: tb/tb_regfile_ir_limiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_ir_limiter
// Brief    : Self-checking bench: limiter vector table, directed sequences,
//            randomized traffic against a register-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_ir_limiter;

    logic        Clk;
    logic        Reset;
    logic        Load_ir;
    logic [31:0] Entrada;
    logic        RegWrite;
    logic [63:0] WriteData;
    logic [1:0]  lim;
    logic [63:0] LimIn;
    logic [31:0] Instr31_0;
    logic [4:0]  Instr19_15;
    logic [4:0]  Instr24_20;
    logic [4:0]  Instr11_7;
    logic [6:0]  Instr6_0;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic [63:0] LimOut;

    regfile_ir_limiter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load_ir    (Load_ir),
        .Entrada    (Entrada),
        .RegWrite   (RegWrite),
        .WriteData  (WriteData),
        .lim        (lim),
        .LimIn      (LimIn),
        .Instr31_0  (Instr31_0),
        .Instr19_15 (Instr19_15),
        .Instr24_20 (Instr24_20),
        .Instr11_7  (Instr11_7),
        .Instr6_0   (Instr6_0),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .LimOut     (LimOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: architectural view of IR and the 32 registers.
    logic [31:0] mIr;
    logic [63:0] mRegs [32];

    typedef struct {
        logic [1:0]  lim;
        logic [63:0] limIn;
        logic [63:0] expOut;
    } limVec_t;

    limVec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] limModel(input logic [1:0] l, input logic [63:0] x);
        case (l)
            2'd0:    return x;
            2'd1:    return 64'($signed(x[31:0]));
            2'd2:    return 64'($signed(x[15:0]));
            default: return 64'(x[7:0]);
        endcase
    endfunction

    function automatic logic [63:0] readModel(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : mRegs[a];
    endfunction

    task automatic modelClear();
        mIr = '0;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
    endtask

    // Captures the inputs held before the edge, then applies them to the model.
    task automatic tick();
        logic [4:0]  rd;
        logic        wr, ld, rs;
        logic [63:0] wd;
        logic [31:0] en;
        rd = mIr[11:7];
        wr = RegWrite; ld = Load_ir; rs = Reset;
        wd = WriteData; en = Entrada;
        @(posedge Clk);
        #1;
        if (!rs) begin
            if (wr && rd != 5'd0) mRegs[rd] = wd;
            if (ld) mIr = en;
        end
    endtask

    task automatic checkAll(input string tag);
        #1;
        chk({tag, ".Instr31_0"},  64'(Instr31_0),  64'(mIr));
        chk({tag, ".Instr19_15"}, 64'(Instr19_15), 64'(mIr[19:15]));
        chk({tag, ".Instr24_20"}, 64'(Instr24_20), 64'(mIr[24:20]));
        chk({tag, ".Instr11_7"},  64'(Instr11_7),  64'(mIr[11:7]));
        chk({tag, ".Instr6_0"},   64'(Instr6_0),   64'(mIr[6:0]));
        chk({tag, ".ReadData1"},  ReadData1, readModel(mIr[19:15]));
        chk({tag, ".ReadData2"},  ReadData2, readModel(mIr[24:20]));
        chk({tag, ".LimOut"},     LimOut,    limModel(lim, LimIn));
    endtask

    initial begin
        vecs[0] = '{2'b00, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vecs[1] = '{2'b01, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_89AB_CDEF};
        vecs[2] = '{2'b10, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_CDEF};
        vecs[3] = '{2'b11, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_00EF};
        vecs[4] = '{2'b10, 64'h0000_0000_7FFF_7FFF, 64'h0000_0000_0000_7FFF};
        vecs[5] = '{2'b01, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};
        vecs[6] = '{2'b11, 64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080};
        vecs[7] = '{2'b10, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_8000};

        Reset = 1'b1; Load_ir = 1'b0; Entrada = '0; RegWrite = 1'b0;
        WriteData = '0; lim = 2'b00; LimIn = 64'h0123_4567_89AB_CDEF;
        modelClear();

        // Reset state; limiter stays live during reset.
        #2;
        chk("rst.Instr31_0", 64'(Instr31_0), 64'd0);
        chk("rst.ReadData1", ReadData1, 64'd0);
        chk("rst.ReadData2", ReadData2, 64'd0);
        chk("rst.LimOut",    LimOut,    64'h0123_4567_89AB_CDEF);

        foreach (vecs[i]) begin
            lim = vecs[i].lim; LimIn = vecs[i].limIn;
            #1;
            chk($sformatf("limvec%0d", i), LimOut, vecs[i].expOut);
        end

        @(negedge Clk);
        Reset = 1'b0;

        // IR load and hold.
        Entrada = 32'h00B5_0533; Load_ir = 1'b1;
        tick();
        Load_ir = 1'b0; Entrada = 32'hDEAD_BEEF;
        #1;
        chk("ir.opcode", 64'(Instr6_0),   64'h33);
        chk("ir.rd",     64'(Instr11_7),  64'd10);
        chk("ir.rs1",    64'(Instr19_15), 64'd10);
        chk("ir.rs2",    64'(Instr24_20), 64'd11);
        tick();
        chk("ir.hold", 64'(Instr31_0), 64'h00B5_0533);

        // Write x5, no bypass during the write cycle.
        Entrada = 32'h0002_82B3; Load_ir = 1'b1;
        tick();
        Load_ir = 1'b0; RegWrite = 1'b1; WriteData = 64'h1122_3344_5566_7788;
        #1;
        chk("wr.during", ReadData1, 64'd0);
        tick();
        RegWrite = 1'b0;
        chk("wr.after", ReadData1, 64'h1122_3344_5566_7788);

        // x0 ignores writes.
        Entrada = 32'h0000_0033; Load_ir = 1'b1;
        tick();
        Load_ir = 1'b0; RegWrite = 1'b1; WriteData = '1;
        tick();
        RegWrite = 1'b0;
        chk("x0.rd1", ReadData1, 64'd0);
        chk("x0.rd2", ReadData2, 64'd0);

        // Simultaneous load and write: write uses old rd (x0), so x7 stays 0.
        Entrada = 32'h0003_83B3; Load_ir = 1'b1; RegWrite = 1'b1; WriteData = 64'h55;
        tick();
        Load_ir = 1'b0;
        chk("same.old_rd", ReadData1, 64'd0);
        tick();
        RegWrite = 1'b0;
        chk("same.x7", ReadData1, 64'h55);

        // Asynchronous reset between edges, pending write discarded.
        Entrada = 32'h0001_81B3; Load_ir = 1'b1;
        tick();
        Load_ir = 1'b0; RegWrite = 1'b1; WriteData = 64'hAA;
        tick();
        RegWrite = 1'b0;
        chk("ar.x3", ReadData1, 64'hAA);
        #2;
        Reset = 1'b1; RegWrite = 1'b1; Load_ir = 1'b1; Entrada = 32'h0001_81B3;
        modelClear();
        #1;
        chk("ar.rd1",   ReadData1, 64'd0);
        chk("ar.instr", 64'(Instr31_0), 64'd0);
        tick();
        Reset = 1'b0; RegWrite = 1'b0;
        checkAll("ar.blocked");
        tick();
        checkAll("ar.first_edge");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            Load_ir   = ($urandom_range(0, 1) == 1);
            RegWrite  = ($urandom_range(0, 9) < 6);
            Entrada   = $urandom;
            WriteData = {$urandom, $urandom};
            lim       = 2'($urandom_range(0, 3));
            LimIn     = {$urandom, $urandom};
            if ($urandom_range(0, 39) == 0) begin
                Reset = 1'b1;
                modelClear();
            end
            tick();
            Reset = 1'b0;
            checkAll($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
